// File: rtl/seg_serial_rx.sv
// -----------------------------------------------------------------------------
// seg_serial_rx
//
// Receiver for the 4-wire serial LED interface (sclk, sclrn, sdt, sen) produced
// by the parallel-to-serial shifter of the 7-segment/LED display path. The
// serial lines are oversampled on the system clock, the DATA_BITS-bit frame is
// rebuilt in a shift register and handed out in parallel on a latch event.
//
// Parameters
//   DATA_BITS : frame length in bits (2..64)
//   DIR       : 0 = first received bit ends in data[DATA_BITS-1] (shift left)
//               1 = first received bit ends in data[0]           (shift right)
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rstn      in   asynchronous active-low reset
//   sclk      in   serial clock (async to clk), data taken on its rising edge
//   sdt       in   serial data
//   sen       in   latch enable, rising edge closes a frame
//   sclrn     in   serial clear, active-low
//   data      out  last good frame (DATA_BITS)
//   valid     out  one-cycle pulse when data updates
//   frame_err out  one-cycle pulse when a frame closes with the wrong length
//   busy      out  high while a frame is partially received
//
// Output handshake: valid and frame_err are single-cycle strobes with no
// ready/backpressure. A consumer must sample data in the cycle valid is high
// (data also holds until the next good frame). valid and frame_err are
// mutually exclusive.
//
// Optional feature (macro SEG_SERIAL_RX_STATS_EN):
//   good_cnt  out  16-bit count of valid pulses (wraps, cleared by rstn only)
//   err_cnt   out  16-bit count of frame_err pulses (wraps, cleared by rstn only)
//
// Latency: valid rises on the 4th rising clk edge after sen rises at the pin
// (two synchroniser flops, one registered edge strobe, one output register).
// -----------------------------------------------------------------------------
module seg_serial_rx #(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned DIR       = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sclk,
  input  logic                 sdt,
  input  logic                 sen,
  input  logic                 sclrn,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef SEG_SERIAL_RX_STATS_EN
  ,
  output logic [15:0]          good_cnt,
  output logic [15:0]          err_cnt
`endif
);

  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // cnt == 0
    SHIFT = 2'd1,  // 0 < cnt < DATA_BITS
    FULL  = 2'd2,  // cnt == DATA_BITS, waiting for sen
    OVER  = 2'd3   // too many bits seen, waiting for sen or clear
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers.
  // sclk and sen: two sync flops plus a third copy for edge detection.
  // sdt: two sync flops plus one extra stage so the sampled bit lines up with
  // the registered sclk rise strobe (both reflect the pin at the same edge).
  // sclrn: level only, two sync flops.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync_q;
  logic [2:0] sen_sync_q;
  logic [1:0] sdt_sync_q;
  logic [1:0] sclrn_sync_q;
  logic       sdt_bit_q;
  logic       sclk_rise_q;
  logic       sen_rise_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q  <= '0;
      sen_sync_q   <= '0;
      sdt_sync_q   <= '0;
      sclrn_sync_q <= '0;
      sdt_bit_q    <= 1'b0;
      sclk_rise_q  <= 1'b0;
      sen_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
      sen_sync_q   <= {sen_sync_q[1:0], sen};
      sdt_sync_q   <= {sdt_sync_q[0], sdt};
      sclrn_sync_q <= {sclrn_sync_q[0], sclrn};
      sdt_bit_q    <= sdt_sync_q[1];
      // Edge strobes are registered so the FSM sees a clean one-cycle pulse.
      sclk_rise_q  <= sclk_sync_q[1] & ~sclk_sync_q[2];
      sen_rise_q   <= sen_sync_q[1] & ~sen_sync_q[2];
    end
  end

  logic sclrn_s;
  assign sclrn_s = sclrn_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // Shift register contents after taking in sdt_bit_q.
  logic [DATA_BITS-1:0]   shreg_shifted;
  logic [CW-1:0]          cnt_inc;

  generate
    if (DIR == 0) begin : g_shift_left
      assign shreg_shifted = {shreg_q[DATA_BITS-2:0], sdt_bit_q};
    end else begin : g_shift_right
      assign shreg_shifted = {sdt_bit_q, shreg_q[DATA_BITS-1:1]};
    end
  endgenerate

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!sclrn_s) begin
      // Clear wins over any edge seen in the same cycle; data is kept.
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else begin
      // The sclk edge is applied first so a coincident sen edge judges the
      // frame on the updated count (the final bit is included).
      if (sclk_rise_q) begin
        unique case (state_q)
          IDLE, SHIFT: begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CNT_FULL) ? FULL : SHIFT;
          end
          FULL: begin
            // One bit too many: freeze the register, count stays saturated.
            state_d = OVER;
          end
          default: begin
            // OVER: ignore further bits.
          end
        endcase
      end

      if (sen_rise_q) begin
        if (state_d == FULL) begin
          data_d  = shreg_d;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

`ifdef SEG_SERIAL_RX_STATS_EN
  // ---------------------------------------------------------------------------
  // Frame statistics; counters advance together with the strobe they count.
  // ---------------------------------------------------------------------------
  logic [15:0] good_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (valid_d) good_cnt_q <= good_cnt_q + 16'd1;
      if (err_d)   err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign good_cnt = good_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_seg_serial_rx
//
// Two receivers: dut64 (64 bits, MSB first) and dut8 (8 bits, LSB first), each
// with its own serial pins. Expected frame outcomes are pushed into per-DUT
// queues when a frame is driven and popped by a monitor whenever the DUT
// strobes valid or frame_err.
// -----------------------------------------------------------------------------
module tb_seg_serial_rx;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [1:0] sclk_p, sdt_p, sen_p, sclrn_p;

  logic [63:0] data64;
  logic        valid64, err64, busy64;
  logic [7:0]  data8;
  logic        valid8, err8, busy8;
`ifdef SEG_SERIAL_RX_STATS_EN
  logic [15:0] good64, errc64, good8, errc8;
`endif

  seg_serial_rx #(.DATA_BITS(64), .DIR(0)) dut64 (
    .clk(clk), .rstn(rstn), .sclk(sclk_p[0]), .sdt(sdt_p[0]), .sen(sen_p[0]),
    .sclrn(sclrn_p[0]), .data(data64), .valid(valid64), .frame_err(err64),
    .busy(busy64)
`ifdef SEG_SERIAL_RX_STATS_EN
    , .good_cnt(good64), .err_cnt(errc64)
`endif
  );

  seg_serial_rx #(.DATA_BITS(8), .DIR(1)) dut8 (
    .clk(clk), .rstn(rstn), .sclk(sclk_p[1]), .sdt(sdt_p[1]), .sen(sen_p[1]),
    .sclrn(sclrn_p[1]), .data(data8), .valid(valid8), .frame_err(err8),
    .busy(busy8)
`ifdef SEG_SERIAL_RX_STATS_EN
    , .good_cnt(good8), .err_cnt(errc8)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  // bit [W] = 1 for frame_err, 0 for valid; low bits = expected data
  logic [64:0] exp_q[$];
  logic [8:0]  exp8_q[$];

  logic [63:0] last_good64;
  logic [7:0]  last_good8;
  int          good_exp[2];
  int          err_exp[2];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (valid64 || err64) begin
        check("dut64_excl", 64'(valid64 & err64), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut64_unexpected: valid=%0b err=%0b data=%h", valid64, err64, data64);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("dut64_kind_err", 64'(err64), 64'(e[64]));
          check("dut64_data", data64, e[63:0]);
        end
      end
      if (valid8 || err8) begin
        check("dut8_excl", 64'(valid8 & err8), 64'd0);
        if (exp8_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut8_unexpected: valid=%0b err=%0b data=%h", valid8, err8, data8);
        end else begin
          logic [8:0] e8;
          e8 = exp8_q.pop_front();
          check("dut8_kind_err", 64'(err8), 64'(e8[8]));
          check("dut8_data", 64'(data8), 64'(e8[7:0]));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy64 : busy8;
  endfunction

  function automatic logic frame_bit(input int d, input logic [63:0] v, input int i);
    if (d == 0) return v[63 - (i % 64)];
    return v[i % 8];
  endfunction

  task automatic send_bit(input int d, input logic b);
    sdt_p[d] = b;
    tick(3);
    sclk_p[d] = 1'b1;
    tick(3);
    sclk_p[d] = 1'b0;
    tick(3);
  endtask

  task automatic pulse_sen(input int d);
    sen_p[d] = 1'b1;
    tick(4);
    sen_p[d] = 1'b0;
    tick(3);
  endtask

  // Record the outcome the bench expects for the next sen event.
  task automatic expect_frame(input int d, input logic ok, input logic [63:0] v);
    if (d == 0) begin
      if (ok) begin
        last_good64 = v;
        good_exp[0]++;
      end else begin
        err_exp[0]++;
      end
      exp_q.push_back({~ok, last_good64});
    end else begin
      if (ok) begin
        last_good8 = v[7:0];
        good_exp[1]++;
      end else begin
        err_exp[1]++;
      end
      exp8_q.push_back({~ok, last_good8});
    end
  endtask

  task automatic wait_drain(input int d);
    int k;
    k = 0;
    while (((d == 0) ? exp_q.size() : exp8_q.size()) != 0 && k < 20) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (((d == 0) ? exp_q.size() : exp8_q.size()) != 0) begin
      n_fail++;
      $display("FAIL event_timeout: dut%0d still waiting for %0d frame events",
               d, (d == 0) ? exp_q.size() : exp8_q.size());
      if (d == 0) exp_q.delete();
      else exp8_q.delete();
    end
  endtask

  // Drive a frame of nbits bits followed by sen. With coincident set, the
  // last sclk rise and the sen rise are driven on the same cycle.
  task automatic run_frame(input int d, input int nbits, input logic [63:0] v,
                           input logic ok, input logic coincident);
    check("busy_before_frame", 64'(get_busy(d)), 64'd0);
    expect_frame(d, ok, v);
    for (int i = 0; i < nbits; i++) begin
      if (coincident && i == nbits - 1) begin
        sdt_p[d] = frame_bit(d, v, i);
        tick(3);
        sclk_p[d] = 1'b1;
        sen_p[d]  = 1'b1;
        tick(4);
        sclk_p[d] = 1'b0;
        sen_p[d]  = 1'b0;
        tick(3);
      end else begin
        send_bit(d, frame_bit(d, v, i));
      end
      if (i == 0 && !(coincident && nbits == 1))
        check("busy_after_first_bit", 64'(get_busy(d)), 64'd1);
    end
    if (!coincident) begin
      if (nbits > 0) check("busy_before_sen", 64'(get_busy(d)), 64'd1);
      pulse_sen(d);
    end
    wait_drain(d);
    check("busy_after_sen", 64'(get_busy(d)), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          d;
    int          nbits;
    logic [63:0] value;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[9];

  // Global time guard.
  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rv;

    vecs[0] = '{0, 64, 64'hDEADBEEF_CAFEF00D, 1'b1};
    vecs[1] = '{0, 63, 64'h1111_2222_3333_4444, 1'b0};  // short frame
    vecs[2] = '{0, 65, 64'h5555_6666_7777_8888, 1'b0};  // long frame
    vecs[3] = '{0, 0,  64'h0,                    1'b0};  // sen with no bits
    vecs[4] = '{1, 8,  64'hA5,                   1'b1};  // LSB-first
    vecs[5] = '{1, 7,  64'h3C,                   1'b0};
    vecs[6] = '{1, 9,  64'h5A,                   1'b0};
    vecs[7] = '{1, 8,  64'h5A,                   1'b1};
    rv = {$urandom(), $urandom()};
    vecs[8] = '{0, 64, rv, 1'b1};

    rstn        = 1'b0;
    sclk_p      = '0;
    sdt_p       = '0;
    sen_p       = '0;
    sclrn_p     = 2'b11;
    last_good64 = '0;
    last_good8  = '0;
    good_exp    = '{0, 0};
    err_exp     = '{0, 0};
    tick(3);
    rstn = 1'b1;
    tick(5);

    // Reset state
    check("reset_data64", data64, 64'd0);
    check("reset_valid64", 64'(valid64), 64'd0);
    check("reset_err64", 64'(err64), 64'd0);
    check("reset_busy64", 64'(busy64), 64'd0);
    check("reset_data8", 64'(data8), 64'd0);

    // MSB-first frame with explicit latency check: valid on the 4th edge
    // after the sen rise, for exactly one cycle.
    expect_frame(0, 1'b1, 64'h0123456789ABCDEF);
    for (int i = 0; i < 64; i++) send_bit(0, frame_bit(0, 64'h0123456789ABCDEF, i));
    sen_p[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_valid_edge%0d", k), 64'(valid64), 64'(k == 4));
      check($sformatf("latency_err_edge%0d", k), 64'(err64), 64'd0);
      if (k == 4) check("latency_data", data64, 64'h0123456789ABCDEF);
    end
    sen_p[0] = 1'b0;
    tick(3);
    wait_drain(0);

    // Table-driven frames
    foreach (vecs[i])
      run_frame(vecs[i].d, vecs[i].nbits, vecs[i].value, vecs[i].exp_ok, 1'b0);

    // Clear mid-frame: partial frame discarded silently.
    for (int i = 0; i < 20; i++) send_bit(0, 1'($urandom_range(0, 1)));
    sclrn_p[0] = 1'b0;
    tick(4);
    sclrn_p[0] = 1'b1;
    tick(4);
    check("busy_after_clear", 64'(busy64), 64'd0);
    check("data_after_clear", data64, last_good64);
    run_frame(0, 64, 64'hFFFF0000FFFF0000, 1'b1, 1'b0);

    // Last sclk rise coincident with sen rise.
    run_frame(0, 64, 64'h8000_0000_0000_0001 | {$urandom(), $urandom()}, 1'b1, 1'b1);
    run_frame(1, 8, 64'h81, 1'b1, 1'b1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 20; i++) send_bit(0, 1'($urandom_range(0, 1)));
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_data64", data64, 64'd0);
    check("async_rst_busy64", 64'(busy64), 64'd0);
    check("async_rst_valid64", 64'(valid64), 64'd0);
    check("async_rst_err64", 64'(err64), 64'd0);
    check("async_rst_data8", 64'(data8), 64'd0);
    last_good64 = '0;
    last_good8  = '0;
    good_exp    = '{0, 0};
    err_exp     = '{0, 0};
    tick(2);
    rstn = 1'b1;
    tick(5);
    run_frame(0, 64, 64'hC3C3_1234_5678_9ABC, 1'b1, 1'b0);

    // Mix of good and bad frames after reset for the statistics counters.
    run_frame(0, 64, {$urandom(), $urandom()}, 1'b1, 1'b0);
    run_frame(0, 10, 64'h0, 1'b0, 1'b0);
    run_frame(0, 64, {$urandom(), $urandom()}, 1'b1, 1'b0);
    run_frame(0, 0, 64'h0, 1'b0, 1'b0);
    run_frame(1, 8, 64'h3E, 1'b1, 1'b0);
    run_frame(1, 3, 64'h00, 1'b0, 1'b0);

`ifdef SEG_SERIAL_RX_STATS_EN
    check("good_cnt64", 64'(good64), 64'(good_exp[0]));
    check("err_cnt64", 64'(errc64), 64'(err_exp[0]));
    check("good_cnt8", 64'(good8), 64'(good_exp[1]));
    check("err_cnt8", 64'(errc8), 64'(err_exp[1]));
`endif

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_serial_rx.md
Name: seg_serial_rx

Overview:
- Receiver end of the 4-wire serial LED interface (sclk, sclrn, sout, sen) driven by the parallel-to-serial shifter of the 7-segment/LED display path.
- Oversamples the serial lines on the system clock, reconstructs the DATA_BITS-bit frame and presents it in parallel with a one-cycle valid strobe.
- Used as a display-side loopback monitor in simulation and on-board self-test, and as a serial switch/keypad input port.

Parameters:
- DATA_BITS, 64, frame length in bits (2..64).
- DIR, 0, bit order. 0: first bit received lands in data[DATA_BITS-1] (shift left). 1: first bit lands in data[0] (shift right).

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rstn, input, 1, reset, asynchronous, active-low.
- sclk, input, 1, serial clock, asynchronous to clk; data sampled on its rising edge.
- sdt, input, 1, serial data.
- sen, input, 1, latch enable; rising edge ends a frame.
- sclrn, input, 1, serial clear, active-low.
- data, output, DATA_BITS, last good frame.
- valid, output, 1, one-cycle pulse when data updates.
- frame_err, output, 1, one-cycle pulse on a bad frame.
- busy, output, 1, high while a frame is partially received.

Behaviour:
- Synchronisation
  - sclk, sdt, sen and sclrn each pass through a 2-flop synchroniser.
  - Edge detect compares the synchronised value with a third registered copy.
  - Inputs must stay stable at least 3 clk periods per level. sdt must be stable 2 clk periods before and after each sclk rise.
- Reset (rstn low, asynchronous)
  - data=0, valid=0, frame_err=0, busy=0.
  - Shift register, bit counter and synchronisers cleared. State=IDLE.
- Bit counter cnt is 0..DATA_BITS and saturates.
- States
  - IDLE (cnt=0): sclk rise → shift bit, cnt=1, go to SHIFT.
  - SHIFT (0<cnt<DATA_BITS): sclk rise → shift, cnt+1. Go to FULL when cnt reaches DATA_BITS.
  - FULL (cnt=DATA_BITS): a further sclk rise → OVER. Shift register is frozen.
  - OVER: sclk rises ignored until sen rise or clear.
- sen rise in FULL
  - data <= shift register, valid=1 for one cycle.
  - Return to IDLE with cnt=0.
- sen rise in IDLE, SHIFT or OVER
  - frame_err=1 for one cycle; data unchanged.
  - Return to IDLE with cnt=0.
- sclk rise and sen rise detected in the same cycle: the bit is shifted and counted first, then the sen rule is evaluated on the updated count.
- Synchronised sclrn low
  - Shift register and cnt cleared, state=IDLE, no valid and no frame_err.
  - Overrides any edge detected in the same cycle.
  - data holds its last value.
- busy = (state != IDLE).
- Latency: valid asserts on the 4th rising clk edge after sen rises at the pin (2 sync + 1 edge register + 1 output register). The new data is visible in the same cycle as valid.
- valid and frame_err are never high together.
- Reset mid-frame discards the partial frame with no pulse.

Optional Feature:
- Macro: SEG_SERIAL_RX_STATS_EN.
- With it: adds outputs good_cnt[15:0] and err_cnt[15:0].
  - good_cnt increments on each valid; err_cnt increments on each frame_err.
  - Both wrap from 0xFFFF to 0 and are cleared by rstn only.
- Without it: the ports and counters are absent.
- All other behaviour is identical in both cases.

Test Plan:
- Frame MSB-first: DATA_BITS=64, DIR=0, send 0x0123456789ABCDEF MSB first, then pulse sen → data=0x0123456789ABCDEF, valid high exactly 1 cycle, 4 clk edges after sen rise, frame_err=0.
- Frame LSB-first: DIR=1, send 0xA5 LSB first with DATA_BITS=8 → data=0xA5, valid pulse.
- Short and long frames: send 63 bits then sen → frame_err pulse, data keeps previous value. Send 65 bits then sen → frame_err pulse, busy high from first bit until the sen event.
- Clear mid-frame: send 20 bits, pulse sclrn low 4 cycles, then send a full 64-bit frame 0xFFFF0000FFFF0000 + sen → data=0xFFFF0000FFFF0000, no frame_err.
- Coincident and reset cases:
  - 64th sclk rise coincident with sen rise → valid, with the 64th bit included.
  - rstn asserted mid-frame → all outputs 0 immediately (asynchronous); next full frame received correctly.
- Stats (SEG_SERIAL_RX_STATS_EN): 3 good frames + 2 bad frames → good_cnt=3, err_cnt=2.
